// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse_meter block and its counter.
package pulse_meter_pkg;

  localparam int unsigned PM_CNT_W = 24;

  typedef enum logic [1:0] {
    PM_IDLE = 2'd0,
    PM_HIGH = 2'd1,
    PM_LOW  = 2'd2
  } pm_state_e;

endpackage

// File: rtl/sat_counter.sv
// Cycle counter: synchronous clear, load-to-1, saturating increment, async reset.
module sat_counter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned CNT_W = PM_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_d;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = CNT_W'(1);
    end else if (inc && (q != '1)) begin
      q_d = q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/pulse_meter.sv
// High-time / period meter fed by edge strobes, with a valid/ready result holding register.
// Define PULSE_METER_TIMEOUT_EN to enable stall detection against TIMEOUT.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int unsigned      CNT_W   = PM_CNT_W,
  parameter logic [CNT_W-1:0] TIMEOUT = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             seq_posedge,
  input  logic             seq_negedge,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             timeout
);

  pm_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic             pos, neg, stall;
  logic             load, inc, clr, produce;
  logic             valid_d, overrun_d;

  // Coincident strobes cancel each other out.
  assign pos = enable & seq_posedge & ~seq_negedge;
  assign neg = enable & seq_negedge & ~seq_posedge;

`ifdef PULSE_METER_TIMEOUT_EN
  assign stall = enable && (state_q != PM_IDLE) && (cnt == TIMEOUT);
`else
  assign stall = 1'b0;
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d    = state_q;
    high_cap_d = high_cap_q;
    load       = 1'b0;
    produce    = 1'b0;
    if (!enable || stall) begin
      state_d = PM_IDLE;
    end else begin
      unique case (state_q)
        PM_IDLE: begin
          if (pos) begin
            state_d = PM_HIGH;
            load    = 1'b1;
          end
        end
        PM_HIGH: begin
          if (pos) begin
            load = 1'b1;
          end else if (neg) begin
            state_d    = PM_LOW;
            high_cap_d = cnt;
          end
        end
        PM_LOW: begin
          if (pos) begin
            state_d = PM_HIGH;
            load    = 1'b1;
            produce = 1'b1;
          end
        end
        default: state_d = PM_IDLE;
      endcase
    end
  end

  assign inc = (state_q == PM_HIGH) || (state_q == PM_LOW);
  assign clr = ~enable | stall;

  always_comb begin
    valid_d = meas_valid;
    if (produce) begin
      valid_d = 1'b1;
    end else if (meas_valid && meas_ready) begin
      valid_d = 1'b0;
    end
  end

  // A result accepted in the same cycle it is replaced is not an overrun.
  assign overrun_d = produce & meas_valid & ~meas_ready;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .load (load),
    .inc  (inc),
    .q    (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PM_IDLE;
      high_cap_q  <= '0;
      meas_high   <= '0;
      meas_period <= '0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q    <= state_d;
      high_cap_q <= high_cap_d;
      meas_valid <= valid_d;
      overrun    <= overrun_d;
      timeout    <= stall;
      if (produce) begin
        meas_high   <= high_cap_q;
        meas_period <= cnt;
      end
    end
  end

endmodule
